// File: rtl/prog_loader.sv
// prog_loader: length-prefixed, checksummed byte-stream loader that fills a program RAM
module prog_loader #(
   parameter int DEPTH = 32,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          we,
   output logic [AW-1:0] mem_in,
   output logic [7:0]    data_in,
   output logic          busy,
   output logic          done,
   output logic          err
);
   localparam int IW = $clog2(DEPTH + 1);
   typedef enum logic [2:0] {IDLE, LEN, LOAD, CSUM, DONE, ERR} state_t;
   state_t        state_q, state_d;
   logic [7:0]    cnt_q, cnt_d, sum_q, sum_d, data_q, data_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          we_q, we_d;
   logic          acc, idle_like;
   assign acc       = in_valid & in_ready;
   assign idle_like = state_q inside {IDLE, DONE, ERR};
   assign we        = we_q;
   assign mem_in    = addr_q;
   assign data_in   = data_q;
   // state register; reset drops straight to IDLE without waiting for a clock
   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   // next state: in_ready is state-only, so a pending byte on in_valid alone decides acceptance
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE, ERR: if (start) state_d = LEN;
         LEN:             if (in_valid) state_d = (in_data == 8'd0 || 32'(in_data) > DEPTH) ? ERR : LOAD;
         LOAD:            if (in_valid && cnt_q == 8'd1) state_d = CSUM;
         CSUM:            if (in_valid) state_d = (in_data == sum_q) ? DONE : ERR;
         default:         state_d = IDLE;
      endcase
   end
   // status outputs; busy stretches over the write pulse that trails the last payload byte
   always_comb begin
      in_ready = state_q inside {LEN, LOAD, CSUM};
      busy     = in_ready | we_q;
      done     = state_q == DONE;
      err      = state_q == ERR;
   end
   // datapath next values: remaining count, write index, running sum and the registered RAM write port
   always_comb begin
      cnt_d  = cnt_q;
      sum_d  = sum_q;
      idx_d  = idx_q;
      addr_d = addr_q;
      data_d = data_q;
      we_d   = 1'b0;
      if (idle_like && start) begin
         idx_d = '0;
         sum_d = '0;
      end
      if (acc && state_q == LEN) cnt_d = in_data;
      if (acc && state_q == LOAD) begin
         we_d   = 1'b1;
         addr_d = AW'(idx_q);
         data_d = in_data;
         idx_d  = idx_q + 1'b1;
         sum_d  = sum_q + in_data;
         cnt_d  = cnt_q - 8'd1;
      end
   end
   // datapath registers; reset clears the write port so a half-done session leaves no further pulse
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt_q  <= '0;
         sum_q  <= '0;
         idx_q  <= '0;
         addr_q <= '0;
         data_q <= '0;
         we_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sum_q  <= sum_d;
         idx_q  <= idx_d;
         addr_q <= addr_d;
         data_q <= data_d;
         we_q   <= we_d;
      end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed sessions with a write scoreboard checked by a negedge monitor
module tb_prog_loader;
   logic       clk = 1'b0;
   logic       rst, start, in_valid;
   logic [7:0] in_data;
   logic       in_ready, we, busy, done, err;
   logic [7:0] mem_in, data_in;
   int         checks = 0;
   int         errors = 0;
   logic [15:0] exp_q[$];

   prog_loader #(.DEPTH(32), .AW(8)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .we(we), .mem_in(mem_in), .data_in(data_in),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic expw(input logic [7:0] a, input logic [7:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic outs_zero(input string name);
      chk({name, " outputs"}, {in_ready, we, busy, done, err, mem_in, data_in}, 0);
   endtask

   task automatic status(input string name, input logic d, input logic e);
      chk({name, " done/err/busy"}, {done, err, busy}, {d, e, 1'b0});
   endtask

   // monitor: every write pulse must match the next queued expectation
   always @(negedge clk) begin
      if (!rst && we) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_in, data_in);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if ({mem_in, data_in} !== e) begin
               errors++;
               $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                        mem_in, data_in, e[15:8], e[7:0]);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      #3;
      outs_zero("reset");
      tick();
      rst = 1'b0;
      tick();
      // bytes offered in IDLE are dropped
      in_valid = 1'b1; in_data = 8'h55;
      tick();
      chk("idle in_ready", in_ready, 1'b0);
      tick();
      in_valid = 1'b0;
      status("idle drop", 1'b0, 1'b0);
      // normal load
      go();
      chk("len in_ready", in_ready, 1'b1);
      expw(8'd0, 8'h11); expw(8'd1, 8'h22); expw(8'd2, 8'h33);
      send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h66);
      tick();
      status("normal", 1'b1, 1'b0);
      chk("hold addr/data", {mem_in, data_in}, {8'd2, 8'h33});
      // bad checksum
      go();
      chk("restart clears done", done, 1'b0);
      expw(8'd0, 8'h01); expw(8'd1, 8'h02);
      send(8'h02); send(8'h01); send(8'h02); send(8'h04);
      tick();
      status("bad csum", 1'b0, 1'b1);
      // bad lengths
      go();
      chk("restart clears err", err, 1'b0);
      send(8'h00);
      tick();
      status("len zero", 1'b0, 1'b1);
      go();
      send(8'd33);
      tick();
      status("len depth+1", 1'b0, 1'b1);
      // full depth
      go();
      send(8'd32);
      for (int i = 0; i < 32; i++) begin
         expw(8'(i), 8'(i + 1));
         send(8'(i + 1));
      end
      send(8'h10);
      tick();
      status("full depth", 1'b1, 1'b0);
      // source stalls during LOAD
      go();
      expw(8'd0, 8'h05); expw(8'd1, 8'h06); expw(8'd2, 8'h07);
      send(8'h03); send(8'h05);
      in_data = 8'hee;
      tick(); tick();
      chk("stall busy", busy, 1'b1);
      send(8'h06); send(8'h07); send(8'h12);
      tick();
      status("stalls", 1'b1, 1'b0);
      // start during LOAD is ignored
      go();
      expw(8'd0, 8'h10); expw(8'd1, 8'h20);
      send(8'h02); send(8'h10);
      start = 1'b1;
      send(8'h20);
      start = 1'b0;
      send(8'h30);
      tick();
      status("start in load", 1'b1, 1'b0);
      // async reset mid-LOAD
      go();
      expw(8'd0, 8'h0a);
      send(8'h04); send(8'h0a); send(8'h0b);
      #1 rst = 1'b1;
      #1;
      outs_zero("async reset");
      tick();
      rst = 1'b0;
      tick();
      go();
      expw(8'd0, 8'h40); expw(8'd1, 8'h41);
      send(8'h02); send(8'h40); send(8'h41); send(8'h81);
      tick();
      status("after reset", 1'b1, 1'b0);
      tick();
      chk("writes drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
